uart_rx_param: RTL and testbench

Parametrised UART receive engine. It detects the start bit, oversamples the serial line, assembles a 5–9 bit character LSB-first, and checks optional parity and 1 or 2 stop bits. The character is presented on a valid/ready output register. It sits between the pad-level rx line and the UART peripheral register file, driven by a shared OVERSAMPLE×baud tick.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx_param.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, parity encodings and parity check for UART RX.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int   c_max_data_bits = 9;
  localparam logic c_parity_even   = 1'b0;
  localparam logic c_parity_odd    = 1'b1;

  // True when data plus the received parity bit disagree with the parity mode.
  function automatic logic parity_mismatch(
    input logic [c_max_data_bits-1:0] data,
    input logic                       par_bit,
    input logic                       odd_mode
  );
    return ((^data) ^ par_bit) != odd_mode;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : 2-FF synchroniser (resets to idle-high) with falling-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  output logic rx_sync,
  output logic rx_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= rx_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rx_sync = r_sync;
  assign rx_fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised oversampling UART receiver with valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int c_tick_w = $clog2(OVERSAMPLE);
  localparam int c_bit_w  = $clog2(DATA_BITS + 1);

  localparam logic [c_tick_w-1:0] c_tick_half = c_tick_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);
  localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);
  localparam logic                c_odd_mode  = (PARITY_ODD != 0) ? c_parity_odd : c_parity_even;

  logic w_rx;
  logic w_fall;

  rx_state_t               r_state,   w_state_nxt;
  logic [c_tick_w-1:0]     r_tick,    w_tick_nxt;
  logic [c_bit_w-1:0]      r_bit,     w_bit_nxt;
  logic [DATA_BITS-1:0]    r_shift,   w_shift_nxt;
  logic                    r_par_err, w_par_err_nxt;
  logic                    r_frm_err, w_frm_err_nxt;
  logic                    w_complete;
  logic                    w_tick_end;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rx_in   (rx_in),
    .rx_sync (w_rx),
    .rx_fall (w_fall)
  );

  assign w_tick_end = sample_tick && (r_tick == c_tick_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_tick    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_par_err <= w_par_err_nxt;
      r_frm_err <= w_frm_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_par_err_nxt = r_par_err;
    w_frm_err_nxt = r_frm_err;
    w_complete    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt   = START;
          w_tick_nxt    = '0;
          w_bit_nxt     = '0;
          w_par_err_nxt = 1'b0;
          w_frm_err_nxt = 1'b0;
        end
      end

      START: begin
        if (sample_tick) begin
          if (r_tick == c_tick_half) begin
            w_tick_nxt  = '0;
            // A high line at mid start bit was only a glitch.
            w_state_nxt = w_rx ? IDLE : DATA;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end

      DATA: begin
        if (w_tick_end) begin
          w_tick_nxt  = '0;
          w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == c_bit_last) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end else if (sample_tick) begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end

      PARITY: begin
        if (w_tick_end) begin
          w_tick_nxt    = '0;
          w_par_err_nxt = parity_mismatch(c_max_data_bits'(r_shift), w_rx, c_odd_mode);
          w_state_nxt   = STOP;
        end else if (sample_tick) begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end

      STOP: begin
        if (w_tick_end) begin
          w_tick_nxt    = '0;
          w_frm_err_nxt = r_frm_err | ~w_rx;
          w_bit_nxt     = r_bit + 1'b1;
          // Leave at mid stop bit so the next start edge is caught early.
          if (r_bit == c_stop_last) begin
            w_bit_nxt   = '0;
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if (sample_tick) begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (w_complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= r_shift;
          parity_err <= r_par_err;
          frame_err  <= w_frm_err_nxt;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Directed bench for uart_rx_param (8N1, 8E1 and 8N2 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

  logic       clk         = 1'b0;
  logic       reset       = 1'b0;
  logic       sample_tick = 1'b0;
  logic [2:0] rx_line     = 3'b111;
  logic [2:0] rx_ready    = 3'b111;
  logic [7:0] rx_data [3];
  logic [2:0] rx_valid, parity_err, frame_err, overrun, busy;

  int total = 0;
  int bad   = 0;

  int par_cfg  [3] = '{0, 1, 0};
  int stop_cfg [3] = '{1, 1, 2};

  logic [7:0] exp_d [3][32];
  logic       exp_p [3][32];
  logic       exp_f [3][32];
  int         wr [3];
  int         rd [3];
  int         exp_ov [3];
  int         ov_seen [3];
  logic [7:0] last_d [3];
  logic       last_p [3];
  logic       last_f [3];

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_8n1 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx_line[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .parity_err(parity_err[0]), .frame_err(frame_err[0]), .overrun(overrun[0]), .busy(busy[0]));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_8e1 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx_line[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .parity_err(parity_err[1]), .frame_err(frame_err[1]), .overrun(overrun[1]), .busy(busy[1]));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_8n2 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx_line[2]),
    .rx_data(rx_data[2]), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]),
    .parity_err(parity_err[2]), .frame_err(frame_err[2]), .overrun(overrun[2]), .busy(busy[2]));

  // One tick every fourth clock.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (sample_tick !== 1'b1);
  endtask

  function automatic logic [15:0] frame(input logic [7:0] d, input int pen, input logic pbit,
                                        input logic s1, input logic s2);
    logic [15:0] v;
    int k;
    v      = '1;
    v[0]   = 1'b0;
    v[8:1] = d;
    k      = 9;
    if (pen != 0) begin
      v[k] = pbit;
      k++;
    end
    v[k]   = s1;
    v[k+1] = s2;
    return v;
  endfunction

  // Character-level prediction from the serial bit pattern.
  task automatic expect_frame(input int i, input logic [15:0] v);
    logic [7:0] d;
    logic p, f;
    int k;
    d = v[8:1];
    p = 1'b0;
    k = 9;
    if (par_cfg[i] != 0) begin
      p = (($countones(d) + int'(v[9])) % 2) != 0;
      k = 10;
    end
    f = 1'b0;
    for (int s = 0; s < stop_cfg[i]; s++) if (v[k+s] == 1'b0) f = 1'b1;
    if (rx_ready[i] == 1'b0 && wr[i] != rd[i]) begin
      exp_ov[i]++;
    end else begin
      exp_d[i][wr[i] % 32] = d;
      exp_p[i][wr[i] % 32] = p;
      exp_f[i][wr[i] % 32] = f;
      wr[i]++;
    end
  endtask

  task automatic send(input int i, input logic [15:0] v);
    int n;
    n = 10 + par_cfg[i] + stop_cfg[i] - 1;
    expect_frame(i, v);
    for (int b = 0; b < n; b++) begin
      rx_line[i] = v[b];
      repeat (16) wait_tick();
      #2;
    end
    rx_line[i] = 1'b1;
    repeat (16) wait_tick();
    #2;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < 3; i++) begin
          if (overrun[i]) ov_seen[i]++;
          if (rx_valid[i]) begin
            if (wr[i] == rd[i]) begin
              chk($sformatf("unexpected_valid_dut%0d", i), {31'd0, rx_valid[i]}, 32'd0);
            end else begin
              chk($sformatf("data_dut%0d", i), {24'd0, rx_data[i]}, {24'd0, exp_d[i][rd[i] % 32]});
              chk($sformatf("parity_err_dut%0d", i), {31'd0, parity_err[i]}, {31'd0, exp_p[i][rd[i] % 32]});
              chk($sformatf("frame_err_dut%0d", i), {31'd0, frame_err[i]}, {31'd0, exp_f[i][rd[i] % 32]});
              if (rx_ready[i]) begin
                last_d[i] = rx_data[i];
                last_p[i] = parity_err[i];
                last_f[i] = frame_err[i];
                rd[i]++;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      wr[i] = 0; rd[i] = 0; exp_ov[i] = 0; ov_seen[i] = 0;
      last_d[i] = 8'hFF; last_p[i] = 1'b1; last_f[i] = 1'b1;
    end

    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_outputs_dut%0d", i),
          {19'd0, rx_data[i], rx_valid[i], parity_err[i], frame_err[i], overrun[i], busy[i]}, 32'd0);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (4) wait_tick();
    #2;

    // 8N1 0xA5 with latency pinned to tick 152.
    fork
      send(0, frame(8'hA5, 0, 1'b0, 1'b1, 1'b1));
      begin
        repeat (151) wait_tick();
        #1 chk("t1_valid_before_152", {31'd0, rx_valid[0]}, 32'd0);
        wait_tick();
        #1 chk("t1_valid_after_152", {31'd0, rx_valid[0]}, 32'd1);
      end
    join
    chk("t1_data", {24'd0, last_d[0]}, 32'hA5);
    chk("t1_flags", {30'd0, last_p[0], last_f[0]}, 32'd0);

    // Start-bit glitch.
    rx_line[0] = 1'b0;
    repeat (4) wait_tick();
    #2 rx_line[0] = 1'b1;
    #1 chk("t2_busy_in_start", {31'd0, busy[0]}, 32'd1);
    repeat (5) wait_tick();
    #1 chk("t2_busy_after_glitch", {31'd0, busy[0]}, 32'd0);
    repeat (32) wait_tick();
    #2 chk("t2_outputs_quiet", {29'd0, rx_valid[0], parity_err[0], frame_err[0]}, 32'd0);

    // Even parity.
    send(1, frame(8'h3C, 1, 1'b1, 1'b1, 1'b1));
    chk("t3_data_bad_parity", {24'd0, last_d[1]}, 32'h3C);
    chk("t3_parity_err_set", {31'd0, last_p[1]}, 32'd1);
    send(1, frame(8'h3C, 1, 1'b0, 1'b1, 1'b1));
    chk("t3_parity_err_clear", {31'd0, last_p[1]}, 32'd0);
    send(1, frame(8'h07, 1, 1'b1, 1'b1, 1'b1));
    chk("t3_odd_data_ok", {31'd0, last_p[1]}, 32'd0);

    // Two stop bits.
    send(2, frame(8'h81, 0, 1'b0, 1'b1, 1'b0));
    chk("t4_data", {24'd0, last_d[2]}, 32'h81);
    chk("t4_frame_err_set", {31'd0, last_f[2]}, 32'd1);
    send(2, frame(8'h7E, 0, 1'b0, 1'b1, 1'b1));
    chk("t4_data_clean", {24'd0, last_d[2]}, 32'h7E);
    chk("t4_frame_err_clear", {31'd0, last_f[2]}, 32'd0);

    // Overrun with consumer stalled.
    rx_ready[0] = 1'b0;
    send(0, frame(8'h11, 0, 1'b0, 1'b1, 1'b1));
    chk("t5_valid_held", {31'd0, rx_valid[0]}, 32'd1);
    send(0, frame(8'h22, 0, 1'b0, 1'b1, 1'b1));
    chk("t5_data_kept", {24'd0, rx_data[0]}, 32'h11);
    chk("t5_overrun_pulses", ov_seen[0], 32'd1);
    rx_ready[0] = 1'b1;
    @(posedge clk);
    #1 chk("t5_valid_cleared", {31'd0, rx_valid[0]}, 32'd0);
    chk("t5_accepted", {24'd0, last_d[0]}, 32'h11);
    wait_tick();
    #2;

    // Reset during DATA of 0x33.
    rx_line[0] = 1'b0;
    repeat (16) wait_tick();
    #2 rx_line[0] = 1'b1;
    repeat (16) wait_tick();
    #2 rx_line[0] = 1'b1;
    repeat (8) wait_tick();
    #1 chk("t6_busy_mid_data", {31'd0, busy[0]}, 32'd1);
    #2 reset = 1'b0;
    #1 chk("t6_outputs_in_reset",
           {19'd0, rx_data[0], rx_valid[0], parity_err[0], frame_err[0], overrun[0], busy[0]}, 32'd0);
    rx_line[0] = 1'b1;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    repeat (32) wait_tick();
    #2;
    send(0, frame(8'h5A, 0, 1'b0, 1'b1, 1'b1));
    chk("t6_data_after_reset", {24'd0, last_d[0]}, 32'h5A);

    // Break: line held low through and past the frame.
    expect_frame(0, frame(8'h00, 0, 1'b0, 1'b0, 1'b0));
    rx_line[0] = 1'b0;
    repeat (10 * 16 + 32) wait_tick();
    #1 chk("t7_idle_while_low", {31'd0, busy[0]}, 32'd0);
    chk("t7_break_data", {24'd0, last_d[0]}, 32'h00);
    chk("t7_break_frame_err", {31'd0, last_f[0]}, 32'd1);
    rx_line[0] = 1'b1;
    repeat (32) wait_tick();
    #2;

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pending_dut%0d", i), wr[i] - rd[i], 32'd0);
      chk($sformatf("overrun_count_dut%0d", i), ov_seen[i], exp_ov[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
